i2c_reg_responder: RTL and testbench
====================================

Name: i2c_reg_responder

Overview:
- I2C target (responder) with a 256 x 8 register file, byte sub-addressed the way the ADV7513 is.
- Answers i2c_master transactions on the shared SCL/SDA pair so that init and register-read logic can be exercised in simulation.
- Can also be built into hardware as a loopback target.
- Runs from the system clock by oversampling SCL/SDA. It never drives SCL; it only pulls SDA low.

Parameters:
- I2C_ADDR, 7'h39, 7-bit target address (the ADV7513 8-bit write address 0x72 shifted right by one).
- CHIP_REV, 8'h13, read-only value at sub-address 0x00.

Ports:
- clock  input  1  system clock, at least 10x the SCL rate.
- reset  input  1  synchronous, active-low.
- SCL  input  1  I2C clock.
- SDA  inout  1  I2C data. Driven 1'b0 when sda_oe is set, otherwise 1'bz.
- wr_strobe  output  1  one-cycle pulse when a data byte is committed to the register file.
- wr_addr  output  8  sub-address of the committed byte.
- wr_data  output  8  committed byte.
- dbg_addr  input  8  host-side inspection address.
- dbg_data  output  8  regfile[dbg_addr], registered, 1-cycle latency.
- busy  output  1  high from a START (own address matched) until STOP or a NACK/mismatch return to IDLE.

Behaviour:
- Input conditioning: SCL and SDA pass through 2-FF synchronizers. Edges are detected on the synchronized copies; total detect latency is 3 clocks.
- START: synchronized SDA falls while SCL is high. Accepted in any state, which covers repeated START. Goes to ADDR, bit count cleared, pointer retained.
- STOP: synchronized SDA rises while SCL is high. Accepted in any state. Goes to IDLE and releases SDA.
- Sampling and driving:
  - SDA is sampled on the detected SCL rise.
  - sda_oe changes only on the clock after a detected SCL fall.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits MSB first (7-bit address + R/W). On the 8th bit: if the address equals I2C_ADDR, go to ADDR_ACK; otherwise go to IDLE with SDA released.
  - ADDR_ACK: drive SDA low for one SCL cycle. R/W=0 goes to SUB. R/W=1 loads the shift register with regfile[ptr] and goes to RDATA.
  - SUB: shift 8 bits into ptr, then go to SUB_ACK (ACK), then WDATA.
  - WDATA: shift 8 bits, then go to WDATA_ACK:
    - pulse wr_strobe with wr_addr=ptr and wr_data=byte;
    - write the regfile, except at ptr==0x00, where the write is ACKed but the register keeps CHIP_REV;
    - ptr increments;
    - return to WDATA.
  - RDATA: drive SDA low for 0 bits and release it for 1 bits, MSB first, 8 bits, then go to MACK.
  - MACK: sample SDA on SCL rise.
    - Low (ACK): ptr++, reload the shift register, return to RDATA.
    - High (NACK): go to IDLE.
- Pointer: 8 bits, wraps 0xFF to 0x00 on both read and write.
- Reset values:
  - state IDLE, sda_oe 0, ptr 0x00, busy 0;
  - wr_strobe 0, wr_addr 0x00, wr_data 0x00, dbg_data 0x00;
  - regfile all 0x00 except 0x00 = CHIP_REV.
- Reset mid-transaction: SDA is released on the first clock with reset low, and any partial byte is discarded.
- Simultaneous events:
  - START/STOP detection takes priority over a data edge in the same clock.
  - A host dbg_addr read of an address being written in the same cycle returns the old value.

Optional Feature:
- Macro I2C_RESP_GLITCH_FILTER_EN.
- Defined: after synchronization, SCL and SDA each pass through a 3-sample shift register. The filtered level changes only when all 3 samples agree. This rejects pulses shorter than 3 clocks and adds 2 clocks to detect latency.
- Undefined: the synchronized signals are used directly.

Test Plan:
- Write path: START, 0x72, 0x41, 0x10, STOP -> three ACKs; wr_strobe pulses once with wr_addr=0x41 and wr_data=0x10; dbg_addr=0x41 gives dbg_data=0x10.
- Read back: write 0x98=0x03, 0x99=0xE0; then START, 0x72, 0x98, repeated START, 0x73, read 2 bytes (ACK then NACK), STOP -> bytes 0x03 then 0xE0; responder in IDLE and busy=0 after the NACK.
- Address mismatch and read-only register:
  - START, 0x74, ... -> no ACK on bit 9, SDA never driven, busy stays 0.
  - Write 0x55 to 0x00 -> ACKed, no regfile change; reads of 0x00 return 0x13.
- Pointer wrap: write 0xFF=0xAA, 0x00=skip, 0x01=0xBB in one burst -> wr_strobe addresses 0xFF, 0x00, 0x01; regfile[0xFF]=0xAA, regfile[0x01]=0xBB.
- Reset mid-read: assert reset during the 4th data bit of a read that is driving SDA low -> SDA is 'z' by the next clock; after release, a new write transaction ACKs normally and regfile[0x00]=0x13.
- Glitch (macro defined): 2-clock low pulse on SCL while idle and during a data bit -> no bit shifted and no state change. With the macro undefined, the same pulse corrupts the byte (checked as expected behaviour).

Source files
------------

// File: rtl/i2c_reg_responder.sv
// I2C register responder: 7-bit target with a 256 x 8 byte-sub-addressed register file.
// Optional build macro I2C_RESP_GLITCH_FILTER_EN adds a 3-sample majority-free agreement filter on SCL/SDA.
module i2c_reg_responder #(
  parameter logic [6:0] I2C_ADDR = 7'h39,
  parameter logic [7:0] CHIP_REV = 8'h13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_MACK
  } state_t;

  state_t      state_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic [7:0]  ptr_r;
  logic        rw_r;
  logic        sda_oe_r;
  logic        busy_r;
  logic        wr_strobe_r;
  logic [7:0]  wr_addr_r;
  logic [7:0]  wr_data_r;
  logic [7:0]  dbg_data_r;
  logic [7:0]  regfile_r [0:255];

  logic        scl_meta_r;
  logic        scl_sync_r;
  logic        sda_meta_r;
  logic        sda_sync_r;
  logic        scl_prev_r;
  logic        sda_prev_r;
  logic        scl_in_s;
  logic        sda_in_s;
  logic        scl_rise_s;
  logic        scl_fall_s;
  logic        start_s;
  logic        stop_s;
  logic [7:0]  ptr_inc_s;

  // Two-flop synchronizers; idle bus level is high, so reset to 1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
    end else begin
      scl_meta_r <= SCL;
      scl_sync_r <= scl_meta_r;
      sda_meta_r <= SDA;
      sda_sync_r <= sda_meta_r;
    end
  end

`ifdef I2C_RESP_GLITCH_FILTER_EN
  logic [1:0] scl_hist_r;
  logic [1:0] sda_hist_r;
  logic       scl_hold_r;
  logic       sda_hold_r;
  logic       scl_filt_s;
  logic       sda_filt_s;

  // Sample history and last agreed level for each line.
  always_ff @(posedge clock) begin
    if (!reset) begin
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_hold_r <= 1'b1;
      sda_hold_r <= 1'b1;
    end else begin
      scl_hist_r <= {scl_hist_r[0], scl_sync_r};
      sda_hist_r <= {sda_hist_r[0], sda_sync_r};
      scl_hold_r <= scl_filt_s;
      sda_hold_r <= sda_filt_s;
    end
  end

  // Level only moves when three consecutive samples agree.
  always_comb begin
    scl_filt_s = scl_hold_r;
    sda_filt_s = sda_hold_r;
    if ({scl_hist_r, scl_sync_r} == 3'b111) begin
      scl_filt_s = 1'b1;
    end else if ({scl_hist_r, scl_sync_r} == 3'b000) begin
      scl_filt_s = 1'b0;
    end else begin
      scl_filt_s = scl_hold_r;
    end
    if ({sda_hist_r, sda_sync_r} == 3'b111) begin
      sda_filt_s = 1'b1;
    end else if ({sda_hist_r, sda_sync_r} == 3'b000) begin
      sda_filt_s = 1'b0;
    end else begin
      sda_filt_s = sda_hold_r;
    end
  end

  assign scl_in_s = scl_filt_s;
  assign sda_in_s = sda_filt_s;
`else
  assign scl_in_s = scl_sync_r;
  assign sda_in_s = sda_sync_r;
`endif

  // Previous conditioned levels for edge and START/STOP detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_prev_r <= scl_in_s;
      sda_prev_r <= sda_in_s;
    end
  end

  assign scl_rise_s = scl_in_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_in_s & scl_prev_r;
  assign start_s    = scl_in_s & scl_prev_r & sda_prev_r & ~sda_in_s;
  assign stop_s     = scl_in_s & scl_prev_r & ~sda_prev_r & sda_in_s;
  assign ptr_inc_s  = ptr_r + 8'd1;

  // Protocol FSM: bits move on SCL rise, SDA drive changes on SCL fall.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      ptr_r       <= 8'h00;
      rw_r        <= 1'b0;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= 8'h00;
      wr_data_r   <= 8'h00;
    end else begin
      wr_strobe_r <= 1'b0;
      if (stop_s) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 3'd0;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b0;
      end else if (start_s) begin
        state_r   <= ST_ADDR;
        bit_cnt_r <= 3'd0;
        sda_oe_r  <= 1'b0;
      end else if (scl_rise_s) begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_ADDR: begin
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              if (shift_r[6:0] == I2C_ADDR) begin
                rw_r    <= sda_in_s;
                busy_r  <= 1'b1;
                state_r <= ST_ADDR_ACK;
              end else begin
                busy_r  <= 1'b0;
                state_r <= ST_IDLE;
              end
            end else begin
              shift_r   <= {shift_r[6:0], sda_in_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          ST_ADDR_ACK: begin
            if (rw_r) begin
              shift_r <= regfile_r[ptr_r];
              state_r <= ST_RDATA;
            end else begin
              state_r <= ST_SUB;
            end
          end
          ST_SUB: begin
            if (bit_cnt_r == 3'd7) begin
              ptr_r     <= {shift_r[6:0], sda_in_s};
              bit_cnt_r <= 3'd0;
              state_r   <= ST_SUB_ACK;
            end else begin
              shift_r   <= {shift_r[6:0], sda_in_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          ST_SUB_ACK: begin
            state_r <= ST_WDATA;
          end
          ST_WDATA: begin
            if (bit_cnt_r == 3'd7) begin
              wr_strobe_r <= 1'b1;
              wr_addr_r   <= ptr_r;
              wr_data_r   <= {shift_r[6:0], sda_in_s};
              ptr_r       <= ptr_inc_s;
              bit_cnt_r   <= 3'd0;
              state_r     <= ST_WDATA_ACK;
            end else begin
              shift_r   <= {shift_r[6:0], sda_in_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          ST_WDATA_ACK: begin
            state_r <= ST_WDATA;
          end
          ST_RDATA: begin
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              state_r   <= ST_MACK;
            end else begin
              shift_r   <= {shift_r[6:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          ST_MACK: begin
            if (!sda_in_s) begin
              ptr_r   <= ptr_inc_s;
              shift_r <= regfile_r[ptr_inc_s];
              state_r <= ST_RDATA;
            end else begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
          default: begin
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        endcase
      end else if (scl_fall_s) begin
        case (state_r)
          ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: sda_oe_r <= 1'b1;
          ST_RDATA:                              sda_oe_r <= ~shift_r[7];
          default:                               sda_oe_r <= 1'b0;
        endcase
      end
    end
  end

  // Register file; sub-address 0x00 is read-only and always holds CHIP_REV.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        regfile_r[i[7:0]] <= (i == 0) ? CHIP_REV : 8'h00;
      end
    end else if (wr_strobe_r && (wr_addr_r != 8'h00)) begin
      regfile_r[wr_addr_r] <= wr_data_r;
    end
  end

  // Host inspection port; a same-cycle write is not forwarded.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dbg_data_r <= 8'h00;
    end else begin
      dbg_data_r <= regfile_r[dbg_addr];
    end
  end

  assign SDA       = sda_oe_r ? 1'b0 : 1'bz;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign dbg_data  = dbg_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Bench for i2c_reg_responder: bit-banged I2C master with write/read scoreboards.
module tb_i2c_reg_responder;

  localparam int Q = 12;

  logic       clock = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  wire        sda_bus;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       busy;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [15:0] mon_exp;
  logic        dut_drove;

  always #5 clock = ~clock;

  assign sda_bus = sda_m ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_reg_responder dut (
    .clock    (clock),
    .reset    (reset),
    .SCL      (scl_m),
    .SDA      (sda_bus),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .busy     (busy)
  );

  // Write scoreboard: every strobe must match the next expected (addr, data).
  always @(negedge clock) begin
    if (reset && wr_strobe) begin
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        $display("FAIL wr_strobe_unexpected got addr=%h data=%h expected no strobe", wr_addr, wr_data);
      end else begin
        mon_exp = exp_wr_q.pop_front();
        if ({wr_addr, wr_data} !== mon_exp)
          $display("FAIL wr_strobe got addr=%h data=%h expected addr=%h data=%h",
                   wr_addr, wr_data, mon_exp[15:8], mon_exp[7:0]);
        else n_pass++;
      end
    end
    if (reset && sda_m && (sda_bus === 1'b0)) dut_drove = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic clock_bit(input logic b, input logic glitch, output logic s);
    sda_m = b; tick(Q);
    scl_m = 1'b1;
    if (glitch) begin
      tick(4); scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(2);
      s = sda_bus; tick(4);
    end else begin
      tick(Q / 2); s = sda_bus; tick(Q / 2);
    end
    scl_m = 1'b0; tick(Q / 2);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], (7 - i) == glitch_bit, s);
    clock_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      v[i] = s;
    end
    clock_bit(~send_ack, 1'b0, s);
  endtask

  task automatic test_reset();
    reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1; dbg_addr = 8'h00;
    tick(3);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b expected=0", busy); else n_pass++;
    n_checks++; if (wr_strobe !== 1'b0) $display("FAIL reset_wr_strobe got=%b expected=0", wr_strobe); else n_pass++;
    n_checks++; if ({wr_addr, wr_data} !== 16'h0000) $display("FAIL reset_wr_bus got=%h expected=0000", {wr_addr, wr_data}); else n_pass++;
    n_checks++; if (dbg_data !== 8'h00) $display("FAIL reset_dbg_data got=%h expected=00", dbg_data); else n_pass++;
    n_checks++; if (sda_bus !== 1'b1) $display("FAIL reset_sda got=%b expected=1", sda_bus); else n_pass++;
    reset = 1'b1; tick(2);
    n_checks++; if (dbg_data !== 8'h13) $display("FAIL reset_chip_rev got=%h expected=13", dbg_data); else n_pass++;
    dbg_addr = 8'h41; tick(2);
    n_checks++; if (dbg_data !== 8'h00) $display("FAIL reset_reg41 got=%h expected=00", dbg_data); else n_pass++;
  endtask

  task automatic test_write_path();
    logic a0, a1, a2;
    exp_wr_q.push_back({8'h41, 8'h10});
    bus_start();
    write_byte(8'h72, -1, a0);
    n_checks++; if (busy !== 1'b1) $display("FAIL write_busy got=%b expected=1", busy); else n_pass++;
    write_byte(8'h41, -1, a1);
    write_byte(8'h10, -1, a2);
    bus_stop(); tick(4);
    n_checks++; if ({a0, a1, a2} !== 3'b111) $display("FAIL write_acks got=%b expected=111", {a0, a1, a2}); else n_pass++;
    n_checks++; if (exp_wr_q.size() != 0) $display("FAIL write_strobe_count got=%0d pending expected=0", exp_wr_q.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL write_busy_after_stop got=%b expected=0", busy); else n_pass++;
    dbg_addr = 8'h41; tick(2);
    n_checks++; if (dbg_data !== 8'h10) $display("FAIL write_dbg41 got=%h expected=10", dbg_data); else n_pass++;
  endtask

  task automatic test_read_back();
    logic a0, a1, a2, a3;
    logic [7:0] v, e;
    exp_wr_q.push_back({8'h98, 8'h03});
    exp_wr_q.push_back({8'h99, 8'hE0});
    bus_start();
    write_byte(8'h72, -1, a0); write_byte(8'h98, -1, a1);
    write_byte(8'h03, -1, a2); write_byte(8'hE0, -1, a3);
    bus_stop(); tick(4);
    n_checks++; if ({a0, a1, a2, a3} !== 4'b1111) $display("FAIL readback_write_acks got=%b expected=1111", {a0, a1, a2, a3}); else n_pass++;
    n_checks++; if (exp_wr_q.size() != 0) $display("FAIL readback_strobes got=%0d pending expected=0", exp_wr_q.size()); else n_pass++;
    bus_start();
    write_byte(8'h72, -1, a0); write_byte(8'h98, -1, a1);
    bus_start();
    write_byte(8'h73, -1, a2);
    n_checks++; if ({a0, a1, a2} !== 3'b111) $display("FAIL readback_addr_acks got=%b expected=111", {a0, a1, a2}); else n_pass++;
    exp_rd_q.push_back(8'h03);
    exp_rd_q.push_back(8'hE0);
    read_byte(1'b1, v); e = exp_rd_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL readback_byte0 got=%h expected=%h", v, e); else n_pass++;
    read_byte(1'b0, v); e = exp_rd_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL readback_byte1 got=%h expected=%h", v, e); else n_pass++;
    tick(4);
    n_checks++; if (busy !== 1'b0) $display("FAIL readback_busy_after_nack got=%b expected=0", busy); else n_pass++;
    bus_stop(); tick(4);
  endtask

  task automatic test_mismatch_readonly();
    logic a0, a1, a2;
    logic [7:0] v, e;
    dut_drove = 1'b0;
    bus_start();
    write_byte(8'h74, -1, a0);
    n_checks++; if (busy !== 1'b0) $display("FAIL mismatch_busy got=%b expected=0", busy); else n_pass++;
    write_byte(8'h00, -1, a1);
    bus_stop(); tick(4);
    n_checks++; if (a0 !== 1'b0) $display("FAIL mismatch_ack got=%b expected=0", a0); else n_pass++;
    n_checks++; if (dut_drove !== 1'b0) $display("FAIL mismatch_sda_driven got=%b expected=0", dut_drove); else n_pass++;
    exp_wr_q.push_back({8'h00, 8'h55});
    bus_start();
    write_byte(8'h72, -1, a0); write_byte(8'h00, -1, a1); write_byte(8'h55, -1, a2);
    bus_stop(); tick(4);
    n_checks++; if ({a0, a1, a2} !== 3'b111) $display("FAIL ro_write_acks got=%b expected=111", {a0, a1, a2}); else n_pass++;
    n_checks++; if (exp_wr_q.size() != 0) $display("FAIL ro_strobe got=%0d pending expected=0", exp_wr_q.size()); else n_pass++;
    dbg_addr = 8'h00; tick(2);
    n_checks++; if (dbg_data !== 8'h13) $display("FAIL ro_dbg00 got=%h expected=13", dbg_data); else n_pass++;
    bus_start();
    write_byte(8'h72, -1, a0); write_byte(8'h00, -1, a1);
    bus_start();
    write_byte(8'h73, -1, a2);
    exp_rd_q.push_back(8'h13);
    read_byte(1'b0, v); e = exp_rd_q.pop_front();
    n_checks++; if (v !== e) $display("FAIL ro_read00 got=%h expected=%h", v, e); else n_pass++;
    bus_stop(); tick(4);
  endtask

  task automatic test_pointer_wrap();
    logic a0, a1, a2, a3, a4;
    exp_wr_q.push_back({8'hFF, 8'hAA});
    exp_wr_q.push_back({8'h00, 8'h55});
    exp_wr_q.push_back({8'h01, 8'hBB});
    bus_start();
    write_byte(8'h72, -1, a0); write_byte(8'hFF, -1, a1);
    write_byte(8'hAA, -1, a2); write_byte(8'h55, -1, a3); write_byte(8'hBB, -1, a4);
    bus_stop(); tick(4);
    n_checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) $display("FAIL wrap_acks got=%b expected=11111", {a0, a1, a2, a3, a4}); else n_pass++;
    n_checks++; if (exp_wr_q.size() != 0) $display("FAIL wrap_strobes got=%0d pending expected=0", exp_wr_q.size()); else n_pass++;
    dbg_addr = 8'hFF; tick(2);
    n_checks++; if (dbg_data !== 8'hAA) $display("FAIL wrap_dbgFF got=%h expected=AA", dbg_data); else n_pass++;
    dbg_addr = 8'h00; tick(2);
    n_checks++; if (dbg_data !== 8'h13) $display("FAIL wrap_dbg00 got=%h expected=13", dbg_data); else n_pass++;
    dbg_addr = 8'h01; tick(2);
    n_checks++; if (dbg_data !== 8'hBB) $display("FAIL wrap_dbg01 got=%h expected=BB", dbg_data); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, s;
    bus_start();
    write_byte(8'h72, -1, a0); write_byte(8'h98, -1, a1);
    bus_start();
    write_byte(8'h73, -1, a2);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b0, s);
    sda_m = 1'b1; tick(Q);
    n_checks++; if (sda_bus !== 1'b0) $display("FAIL midread_driving got=%b expected=0", sda_bus); else n_pass++;
    reset = 1'b0; tick(1);
    n_checks++; if (sda_bus !== 1'b1) $display("FAIL midread_release got=%b expected=1", sda_bus); else n_pass++;
    tick(3); reset = 1'b1; tick(2);
    n_checks++; if (busy !== 1'b0) $display("FAIL midread_busy got=%b expected=0", busy); else n_pass++;
    bus_stop(); tick(4);
    exp_wr_q.push_back({8'h20, 8'h5A});
    bus_start();
    write_byte(8'h72, -1, a0); write_byte(8'h20, -1, a1); write_byte(8'h5A, -1, a2);
    bus_stop(); tick(4);
    n_checks++; if ({a0, a1, a2} !== 3'b111) $display("FAIL postreset_acks got=%b expected=111", {a0, a1, a2}); else n_pass++;
    n_checks++; if (exp_wr_q.size() != 0) $display("FAIL postreset_strobe got=%0d pending expected=0", exp_wr_q.size()); else n_pass++;
    dbg_addr = 8'h00; tick(2);
    n_checks++; if (dbg_data !== 8'h13) $display("FAIL postreset_dbg00 got=%h expected=13", dbg_data); else n_pass++;
    dbg_addr = 8'h98; tick(2);
    n_checks++; if (dbg_data !== 8'h00) $display("FAIL postreset_dbg98 got=%h expected=00", dbg_data); else n_pass++;
  endtask

  task automatic test_glitch();
    logic a0;
    dut_drove = 1'b0;
    tick(4); scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(Q);
    n_checks++; if (busy !== 1'b0) $display("FAIL glitch_idle_busy got=%b expected=0", busy); else n_pass++;
    bus_start();
    write_byte(8'h72, 0, a0);
`ifdef I2C_RESP_GLITCH_FILTER_EN
    n_checks++; if (a0 !== 1'b1) $display("FAIL glitch_filtered_ack got=%b expected=1", a0); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL glitch_filtered_busy got=%b expected=1", busy); else n_pass++;
`else
    n_checks++; if (a0 !== 1'b0) $display("FAIL glitch_corrupt_ack got=%b expected=0", a0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL glitch_corrupt_busy got=%b expected=0", busy); else n_pass++;
    n_checks++; if (dut_drove !== 1'b0) $display("FAIL glitch_corrupt_sda got=%b expected=0", dut_drove); else n_pass++;
`endif
    bus_stop(); tick(4);
    bus_start();
    write_byte(8'h72, -1, a0);
    bus_stop(); tick(4);
    n_checks++; if (a0 !== 1'b1) $display("FAIL glitch_recovery_ack got=%b expected=1", a0); else n_pass++;
  endtask

  initial begin
    dut_drove = 1'b0;
    test_reset();
    test_write_path();
    test_read_back();
    test_mismatch_readonly();
    test_pointer_wrap();
    test_reset_mid_read();
    test_glitch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
